// File: rtl/ssd_probe_display_if.sv
// Probe-select and seven-segment display bundle between the core top and the display block.
interface ssd_probe_display_if #(
   parameter int unsigned NUM_CH = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*DATA_W-1:0] probe_bus;
   logic [CH_W-1:0]          ch_sel;
   logic                     freeze;
   logic [DATA_W-1:0]        value_out;
   logic                     busy;
   logic [DIGITS-1:0]        anode_out;
   logic [6:0]               seg_out;

   modport master (
      output probe_bus, ch_sel, freeze,
      input  value_out, busy, anode_out, seg_out
   );

   modport slave (
      input  probe_bus, ch_sel, freeze,
      output value_out, busy, anode_out, seg_out
   );
endinterface

// File: rtl/ssd_probe_display.sv
// Probe word selector with sequential double-dabble BCD conversion and multiplexed SSD drive.
// Optional macro SSD_LZ_BLANK_EN blanks leading-zero digits.
module ssd_probe_display #(
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DISP_BITS = 13,
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned REFRESH_W = 18
) (
   input logic               clk,
   input logic               rst,
   ssd_probe_display_if.slave bus
);
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // Every 3 binary bits need at most one decimal digit; keep at least DIGITS nibbles.
   localparam int unsigned NB_MIN = (DISP_BITS + 2) / 3;
   localparam int unsigned NB     = (NB_MIN > DIGITS) ? NB_MIN : DIGITS;
   localparam int unsigned SR_W   = 4 * NB + DISP_BITS;
   localparam int unsigned SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W  = $clog2(DISP_BITS + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StConv, StDone} state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   value_q;
   logic                busy_q;
   logic [SR_W-1:0]     sr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [4*DIGITS-1:0] disp_q;
   logic                ovf_q;
   logic [REFRESH_W-1:0] refresh_q;
   logic [DIGITS-1:0]   anode_q;
   logic [6:0]          seg_q;

   logic [DATA_W-1:0]   selected;
   logic [SR_W-1:0]     sr_next;
   logic                ovf_c;
   logic [SEL_W-1:0]    dig_idx;
   logic [DIGITS-1:0]   anode_c;
   logic [3:0]          nib_c;
   logic                lz_c;
   logic [6:0]          seg_c;

   // Out-of-range selects fall through to channel 0.
   always_comb begin
      selected = bus.probe_bus[DATA_W-1:0];
      for (int k = 1; k < NUM_CH; k++) begin
         if (bus.ch_sel == CH_W'(k)) selected = bus.probe_bus[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      sr_next = sr_q;
      for (int i = 0; i < NB; i++) begin
         if (sr_q[DISP_BITS+4*i +: 4] >= 4'd5) begin
            sr_next[DISP_BITS+4*i +: 4] = sr_q[DISP_BITS+4*i +: 4] + 4'd3;
         end
      end
      sr_next = sr_next << 1;
   end

   always_comb begin
      ovf_c = 1'b0;
      for (int i = DIGITS; i < NB; i++) begin
         if (sr_q[DISP_BITS+4*i +: 4] != 4'd0) ovf_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         value_q <= '0;
         busy_q  <= 1'b0;
         sr_q    <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!bus.freeze) state_q <= StLoad;
            end
            StLoad: begin
               value_q <= selected;
               sr_q    <= SR_W'(selected[DISP_BITS-1:0]);
               cnt_q   <= CNT_W'(DISP_BITS);
               busy_q  <= 1'b1;
               state_q <= StConv;
            end
            StConv: begin
               sr_q  <= sr_next;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= StDone;
            end
            StDone: begin
               disp_q  <= sr_q[DISP_BITS +: 4*DIGITS];
               ovf_q   <= ovf_c;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      logic [6:0] c;
      case (n)
         4'd0:    c = 7'b1000000;
         4'd1:    c = 7'b1111001;
         4'd2:    c = 7'b0100100;
         4'd3:    c = 7'b0110000;
         4'd4:    c = 7'b0011001;
         4'd5:    c = 7'b0010010;
         4'd6:    c = 7'b0000010;
         4'd7:    c = 7'b1111000;
         4'd8:    c = 7'b0000000;
         4'd9:    c = 7'b0010000;
         default: c = 7'h7F;
      endcase
      return c;
   endfunction

   assign dig_idx = (DIGITS > 1) ? refresh_q[REFRESH_W-1 -: SEL_W] : '0;

`ifdef SSD_LZ_BLANK_EN
   logic [DIGITS-1:0] nz_from;

   // nz_from[d] is set when digit d or any digit above it is nonzero.
   always_comb begin
      logic nz;
      nz      = 1'b0;
      nz_from = '0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         nz         = nz | (disp_q[4*d +: 4] != 4'd0);
         nz_from[d] = nz;
      end
   end
`endif

   always_comb begin
      anode_c = '1;
      nib_c   = '0;
      lz_c    = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (dig_idx == SEL_W'(d)) begin
            anode_c[d] = 1'b0;
            nib_c      = disp_q[4*d +: 4];
`ifdef SSD_LZ_BLANK_EN
            lz_c       = (d != 0) && !nz_from[d];
`endif
         end
      end
      if (&anode_c)   seg_c = 7'h7F;
      else if (ovf_q) seg_c = 7'b0111111;
      else if (lz_c)  seg_c = 7'h7F;
      else            seg_c = seg_code(nib_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         anode_q   <= '1;
         seg_q     <= 7'h7F;
      end else begin
         refresh_q <= refresh_q + 1'b1;
         anode_q   <= anode_c;
         seg_q     <= seg_c;
      end
   end

   assign bus.value_out = value_q;
   assign bus.busy      = busy_q;
   assign bus.anode_out = anode_q;
   assign bus.seg_out   = seg_q;
endmodule

// File: tb/tb_ssd_probe_display.sv
// Directed bench for ssd_probe_display: a 4-digit instance plus a 3-digit overflow instance.
module tb_ssd_probe_display;
   logic clk;
   logic rst;

   ssd_probe_display_if #(.NUM_CH(16), .DATA_W(32), .DIGITS(4)) ifc0 ();
   ssd_probe_display_if #(.NUM_CH(16), .DATA_W(32), .DIGITS(3)) ifc1 ();

   ssd_probe_display #(
      .NUM_CH(16), .DATA_W(32), .DISP_BITS(13), .DIGITS(4), .REFRESH_W(4)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(ifc0.slave)
   );

   ssd_probe_display #(
      .NUM_CH(16), .DATA_W(32), .DISP_BITS(13), .DIGITS(3), .REFRESH_W(4)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(ifc1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
`ifdef SSD_LZ_BLANK_EN
   localparam int ZB = -1;
`else
   localparam int ZB = 0;
`endif

   int n_checks = 0;
   int n_fails  = 0;
   logic [6:0] seen0 [4];
   logic [6:0] seen1 [3];
   int off1_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // -1 = blank, -2 = dash, otherwise a decimal digit.
   function automatic logic [6:0] code(input int v);
      if (v == -1) return 7'h7F;
      if (v == -2) return 7'b0111111;
      return SEG[v];
   endfunction

   task automatic set_ch(input int k, input logic [31:0] v);
      ifc0.probe_bus[k*32 +: 32] = v;
   endtask

   task automatic scan();
      logic [3:0] m4;
      logic [2:0] m3;
      for (int d = 0; d < 4; d++) seen0[d] = 'x;
      for (int d = 0; d < 3; d++) seen1[d] = 'x;
      off1_cnt = 0;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            m4 = 4'b0001 << d;
            if (ifc0.anode_out == ~m4) seen0[d] = ifc0.seg_out;
         end
         for (int d = 0; d < 3; d++) begin
            m3 = 3'b001 << d;
            if (ifc1.anode_out == ~m3) seen1[d] = ifc1.seg_out;
         end
         if (ifc1.anode_out == 3'b111) off1_cnt++;
      end
   endtask

   task automatic check_disp(input string tag, input int e3, input int e2, input int e1,
                             input int e0);
      scan();
      check({tag, "_d0"}, 32'(seen0[0]), 32'(code(e0)));
      check({tag, "_d1"}, 32'(seen0[1]), 32'(code(e1)));
      check({tag, "_d2"}, 32'(seen0[2]), 32'(code(e2)));
      check({tag, "_d3"}, 32'(seen0[3]), 32'(code(e3)));
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n = 0;
      while (ifc0.busy !== lvl && n < 64) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(ifc0.busy), 32'(lvl));
   endtask

   initial begin
      int bad;
      int n;
      logic seen_busy;

      rst = 1'b0;
      ifc0.probe_bus = '0;
      ifc0.ch_sel    = 4'd3;
      ifc0.freeze    = 1'b0;
      ifc1.probe_bus = '0;
      ifc1.probe_bus[31:0] = 32'd1000;
      ifc1.ch_sel    = 4'd0;
      ifc1.freeze    = 1'b0;
      set_ch(3, 32'h0000_04D2);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(ifc0.busy), 0);
      check("rst_anode", 32'(ifc0.anode_out), 32'hF);
      check("rst_seg", 32'(ifc0.seg_out), 32'h7F);
      check("rst_value", ifc0.value_out, 0);

      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", 32'(ifc0.busy), 0);
      @(posedge clk); #1;
      check("load_busy", 32'(ifc0.busy), 1);
      check("load_value", ifc0.value_out, 32'h0000_04D2);
      repeat (13) @(posedge clk);
      #1 check("conv_last_busy", 32'(ifc0.busy), 1);
      @(posedge clk); #1;
      check("done_busy", 32'(ifc0.busy), 0);
      check_disp("v1234", 1, 2, 3, 4);
      for (int d = 0; d < 3; d++) check("ovf_dash", 32'(seen1[d]), 32'b0111111);
      check("ovf_off_slots", off1_cnt, 4);

      set_ch(3, 32'd7006);
      repeat (40) @(negedge clk);
      check_disp("v7006", 7, 0, 0, 6);

      set_ch(3, 32'hFFFF_E005);
      repeat (40) @(negedge clk);
      check("v5_value", ifc0.value_out, 32'hFFFF_E005);
      check_disp("v5", ZB, ZB, ZB, 5);

      set_ch(3, 32'h0000_1FFF);
      repeat (40) @(negedge clk);
      check_disp("v8191", 8, 1, 9, 1);

      set_ch(9, 32'd0);
      ifc0.ch_sel = 4'd9;
      repeat (34) @(negedge clk);
      check_disp("v0", ZB, ZB, ZB, 0);

      ifc0.ch_sel = 4'd3;
      repeat (40) @(negedge clk);
      wait_busy(1'b1, "pre_freeze_rise");
      wait_busy(1'b0, "pre_freeze_fall");
      ifc0.freeze = 1'b1;
      set_ch(3, 32'd42);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ifc0.value_out !== 32'h0000_1FFF || ifc0.busy !== 1'b0) bad++;
      end
      check("freeze_hold", bad, 0);
      check_disp("frozen", 8, 1, 9, 1);
      check("frozen_value", ifc0.value_out, 32'h0000_1FFF);

      ifc0.freeze = 1'b0;
      n = 0;
      seen_busy = 1'b0;
      while (n < 20 && !(seen_busy && ifc0.busy === 1'b0)) begin
         @(negedge clk);
         n++;
         if (ifc0.busy === 1'b1) seen_busy = 1'b1;
      end
      check("unfreeze_latency_ok", 32'(n <= 16), 1);
      check("unfreeze_value", ifc0.value_out, 32'd42);
      check_disp("v42", ZB, ZB, 4, 2);

      wait_busy(1'b1, "pre_rst_rise");
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_busy", 32'(ifc0.busy), 0);
      check("midrst_anode", 32'(ifc0.anode_out), 32'hF);
      check("midrst_seg", 32'(ifc0.seg_out), 32'h7F);
      check("midrst_value", ifc0.value_out, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_value", ifc0.value_out, 32'd42);
      check_disp("post_rst", ZB, ZB, 4, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/ssd_probe_display.md
Name: ssd_probe_display

Overview:
- Parametrised successor to the fixed 13-bit LED/SSD debug output of the FPGA core top.
- Selects one of NUM_CH 32-bit probe words (PC, ALU out, regfile data, ...) and converts its low DISP_BITS bits to BCD with a sequential double-dabble engine.
- Time-multiplexes the decimal result onto a DIGITS-digit common-anode seven-segment display.
- Sits between the core top and the board pins.

Parameters:
- NUM_CH, 16, number of probe channels on probe_bus.
- DATA_W, 32, width of each probe channel.
- DISP_BITS, 13, low bits of the selected channel that are converted (1..DATA_W).
- DIGITS, 4, number of display digits (1..8).
- REFRESH_W, 18, refresh counter width; digit period is 2^(REFRESH_W - clog2(DIGITS)) clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- probe_bus  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- ch_sel  in  clog2(NUM_CH)  channel select; values >= NUM_CH select 0.
- freeze  in  1  high: hold the current display, take no new samples.
- value_out  out  DATA_W  last captured raw channel word.
- busy  out  1  conversion in progress.
- anode_out  out  DIGITS  digit enables, active-low; bit 0 is the least-significant digit.
- seg_out  out  7  {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=0, async): state IDLE, value_out=0, busy=0, bcd/display registers=0, refresh counter=0, anode_out all 1s, seg_out=7'h7F. All outputs are registered.
- FSM states: IDLE, LOAD, CONV, DONE.
- IDLE -> LOAD on the next clk when freeze=0. Otherwise IDLE is held.
- LOAD (1 cycle):
  - value_out <= selected channel.
  - shift register <= {zeros, selected[DISP_BITS-1:0]}.
  - bit counter <= DISP_BITS; busy <= 1.
- CONV (DISP_BITS cycles), each cycle:
  - Add 3 to every BCD nibble >= 5.
  - Then shift the shift register left 1.
  - Decrement the counter; go to DONE when it reaches 0.
- DONE (1 cycle):
  - Copy the BCD nibbles to the display register atomically; busy <= 0.
  - Go to IDLE.
- Latency from the LOAD edge to display update is DISP_BITS+2 clocks (15 at defaults).
- Sampling is continuous while freeze=0. One full period is DISP_BITS+3 clocks.
- Changes to ch_sel or probe_bus after LOAD do not affect the conversion in progress.
- freeze asserted mid-conversion: the conversion completes and updates the display, then the FSM stays in IDLE.
- The display register changes only in DONE. The display never shows a partial conversion.
- Overflow: if the converted value > 10^DIGITS - 1, every digit shows a dash (seg_out=7'b0111111).
- Scanning:
  - The refresh counter is free-running and wraps at 2^REFRESH_W.
  - Its top clog2(DIGITS) bits select digit d; only anode_out[d] is driven 0.
  - Counter values that map to digit indices >= DIGITS drive all anodes to 1.
  - seg_out is registered together with anode_out, so they are aligned with no ghosting cycle.
- Segment codes (active-low):
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001
  - 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000
  - blank = 7'h7F
- Reset mid-conversion: returns to the reset state immediately. Sampling restarts from LOAD on the second clk after rst releases.

Optional Feature:
- Macro: SSD_LZ_BLANK_EN.
- Defined: leading-zero digits above the most significant nonzero digit show blank (7'h7F). Digit 0 always shows its value, so 0 displays as a single "0". The overflow dash pattern overrides blanking.
- Undefined: all digits show their values, including leading zeros.

Test Plan:
- Defaults with REFRESH_W=4; ch_sel=3, ch3=32'h0000_04D2, freeze=0 -> busy rises after LOAD; 15 clocks later digits {3..0}={1,2,3,4}; while digit 0 is active, anode_out=4'b1110 and seg_out=7'b0011001.
- ch3=32'hFFFF_E005 (low 13 bits = 5) -> value_out=32'hFFFF_E005; digits {0,0,0,5}, or blank,blank,blank,5 with SSD_LZ_BLANK_EN.
- ch3=32'h0000_1FFF -> digits {8,1,9,1}; then ch_sel=9 with ch9=0 -> display becomes {0,0,0,0} within one sample period.
- Overflow: DIGITS=3, value 1000 -> every active digit shows seg_out=7'b0111111.
- freeze=1 after a completed DONE, then change ch3 to 32'd42 -> display and value_out unchanged over 100 clocks; freeze=0 -> 42 appears after <= DISP_BITS+3 clocks.
- rst=0 asserted 5 clocks into CONV -> same cycle: busy=0, anode_out=4'hF, seg_out=7'h7F, value_out=0; after release the next conversion completes normally.
